piso_serializer: RTL and testbench

- Parallel-in serial-out transmitter for the register family; it is the serial-sending end that a SIPO receiver consumes.
- Accepts a WIDTH-bit parallel word on a load/ready handshake and shifts it out one bit per clock with valid/last framing.
- A one-word holding buffer lets a second word be queued during shifting, so back-to-back words stream with no idle gap.

---
 rtl/piso_serializer.sv | 124 ++++++++++++
 tb/tb_piso_serializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: WIDTH-bit word in on load/ready, one bit per clock out with valid/last.
// A one-word hold buffer lets the next word queue behind the current one so words stream with no gap.
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d_in,
   output logic             ready,
   output logic             s_out,
   output logic             s_valid,
   output logic             s_last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             s_out_q, s_out_d;
   logic             s_valid_q, s_valid_d;
   logic             s_last_q, s_last_d;

   logic             accept;
   logic             last_bit;
   logic             start_en;
   logic [WIDTH-1:0] start_word;

   // shift_q holds only the bits still to be sent after the one currently on s_out
   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] tail_bits(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   assign accept   = load && !hold_full_q;
   assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;
      s_out_d     = s_out_q;
      s_valid_d   = s_valid_q;
      s_last_d    = s_last_q;
      start_en    = 1'b0;
      start_word  = d_in;

      if (state_q == S_IDLE) begin
         start_en = accept;
      end else if (!last_bit) begin
         cnt_d    = cnt_q + 1'b1;
         s_out_d  = head_bit(shift_q);
         shift_d  = tail_bits(shift_q);
         s_last_d = (cnt_q == LAST_CNT - 1'b1);
         if (accept) begin
            hold_d      = d_in;
            hold_full_d = 1'b1;
         end
      end else if (hold_full_q) begin
         start_en    = 1'b1;
         start_word  = hold_q;
         hold_full_d = 1'b0;
      end else if (accept) begin
         // bypass: word goes straight to the shifter at the last-bit edge
         start_en = 1'b1;
      end else begin
         state_d   = S_IDLE;
         s_out_d   = 1'b0;
         s_valid_d = 1'b0;
         s_last_d  = 1'b0;
      end

      if (start_en) begin
         state_d   = S_SHIFT;
         shift_d   = tail_bits(start_word);
         s_out_d   = head_bit(start_word);
         cnt_d     = '0;
         s_valid_d = 1'b1;
         s_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
         s_out_q     <= 1'b0;
         s_valid_q   <= 1'b0;
         s_last_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
         s_out_q     <= s_out_d;
         s_valid_q   <= s_valid_d;
         s_last_q    <= s_last_d;
      end
   end

   assign ready   = ~hold_full_q;
   assign s_out   = s_out_q;
   assign s_valid = s_valid_q;
   assign s_last  = s_last_q;
   assign busy    = (state_q == S_SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances driven together, checked against a word-level model.
module tb_piso_serializer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] d_in = '0;

   logic rdy_m, out_m, vld_m, last_m, busy_m;
   logic rdy_l, out_l, vld_l, last_l, busy_l;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .load(load), .d_in(d_in),
      .ready(rdy_m), .s_out(out_m), .s_valid(vld_m), .s_last(last_m), .busy(busy_m));

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .load(load), .d_in(d_in),
      .ready(rdy_l), .s_out(out_l), .s_valid(vld_l), .s_last(last_l), .busy(busy_l));

   // observed: {ready, valid, bit_msb_inst, bit_lsb_inst, last, busy}, with both instances' framing required to agree
   logic [5:0] act;
   assign act = {rdy_m & rdy_l, vld_m & vld_l, out_m, out_l, last_m & last_l, busy_m & busy_l}
              | {rdy_m ^ rdy_l, vld_m ^ vld_l, 2'b00, last_m ^ last_l, busy_m ^ busy_l} << 0;
   logic       framing_agree;
   assign framing_agree = (rdy_m == rdy_l) && (vld_m == vld_l) && (last_m == last_l) && (busy_m == busy_l);

   // Word-level model: current word, index of the bit on the wire, and one held word.
   logic         m_valid = 1'b0;
   int           m_k = 0;
   logic [W-1:0] m_word = '0;
   logic         m_held = 1'b0;
   logic [W-1:0] m_hold = '0;

   task automatic model_reset();
      m_valid = 1'b0;
      m_k     = 0;
      m_held  = 1'b0;
   endtask

   task automatic model_edge(input logic ld, input logic [W-1:0] d);
      logic acc;
      acc = ld && !m_held;
      if (m_valid && m_k != W - 1) begin
         m_k++;
         if (acc) begin
            m_held = 1'b1;
            m_hold = d;
         end
      end else if (m_held) begin
         m_word = m_hold; m_k = 0; m_held = 1'b0; m_valid = 1'b1;
      end else if (acc) begin
         m_word = d; m_k = 0; m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
   endtask

   function automatic logic [5:0] exp_vec();
      logic bm, bl;
      bm = m_valid ? m_word[W-1-m_k] : 1'b0;
      bl = m_valid ? m_word[m_k] : 1'b0;
      return {!m_held, m_valid, bm, bl, m_valid && (m_k == W - 1), m_valid};
   endfunction

   task automatic step(input logic ld, input logic [W-1:0] d);
      load = ld;
      d_in = d;
      model_edge(ld, d);
      @(posedge clk);
      #1;
      load = 1'b0;
      d_in = 4'($urandom);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (act !== 6'b100000) $display("FAIL reset_assert: got %b want %b", act, 6'b100000);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0, 4'h0);
      n_checks++;
      if (act !== 6'b100000 || !framing_agree)
         $display("FAIL reset_release: got %b want %b", act, 6'b100000);
      else n_pass++;
   endtask

   task automatic test_single();
      logic [3:0] sm, sl, sv;
      sm = '0; sl = '0; sv = '0;
      step(1'b1, 4'b1010);
      for (int c = 0; c < 6; c++) begin
         n_checks++;
         if (act !== exp_vec() || !framing_agree)
            $display("FAIL single cyc%0d: got %b want %b", c, act, exp_vec());
         else n_pass++;
         if (c < 4) begin
            sm = {sm[2:0], out_m}; sl = {sl[2:0], out_l}; sv = {sv[2:0], last_m};
         end
         step(1'b0, 4'h0);
      end
      n_checks++;
      if ({sm, sl, sv} !== 12'b1010_0101_0001)
         $display("FAIL single_stream: got %b want %b", {sm, sl, sv}, 12'b1010_0101_0001);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] sm, sl, sv;
      int nbits, rdy_low;
      sm = '0; sl = '0; sv = '0; nbits = 0; rdy_low = 0;
      for (int c = 0; c < 12; c++) begin
         // 1111 is offered while the hold buffer is full and must vanish
         if (c == 0)      step(1'b1, 4'b1010);
         else if (c == 2) step(1'b1, 4'b0001);
         else if (c == 3) step(1'b1, 4'b1111);
         else             step(1'b0, 4'h0);
         n_checks++;
         if (act !== exp_vec() || !framing_agree)
            $display("FAIL b2b cyc%0d: got %b want %b", c, act, exp_vec());
         else n_pass++;
         if (vld_m && nbits < 8) begin
            sm = {sm[6:0], out_m}; sl = {sl[6:0], out_l}; sv = {sv[6:0], last_m}; nbits++;
         end
         if (!rdy_m) rdy_low++;
      end
      n_checks++;
      if ({sm, sl, sv} !== 24'b10100001_01011000_00010001 || nbits != 8)
         $display("FAIL b2b_stream: got %b (%0d bits) want %b", {sm, sl, sv}, nbits, 24'b10100001_01011000_00010001);
      else n_pass++;
      n_checks++;
      if (rdy_low != 2) $display("FAIL b2b_ready_low: got %0d cycles want 2", rdy_low);
      else n_pass++;
   endtask

   task automatic test_bypass();
      logic [7:0] sm;
      int nbits, gaps;
      logic seen_rdy_low;
      sm = '0; nbits = 0; gaps = 0; seen_rdy_low = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (c == 0)      step(1'b1, 4'b1100);
         else if (c == 4) step(1'b1, 4'b0110);
         else             step(1'b0, 4'h0);
         n_checks++;
         if (act !== exp_vec() || !framing_agree)
            $display("FAIL bypass cyc%0d: got %b want %b", c, act, exp_vec());
         else n_pass++;
         if (!rdy_m) seen_rdy_low = 1'b1;
         if (vld_m && nbits < 8) begin sm = {sm[6:0], out_m}; nbits++; end
         if (!vld_m && c < 8) gaps++;
      end
      n_checks++;
      if (sm !== 8'b1100_0110 || gaps != 0 || seen_rdy_low)
         $display("FAIL bypass_stream: got %b gaps=%0d rdy_low=%0b want %b gaps=0 rdy_low=0",
                  sm, gaps, seen_rdy_low, 8'b1100_0110);
      else n_pass++;
   endtask

   task automatic test_reset_midstream();
      step(1'b1, 4'b0001);
      n_checks++;
      if (out_l !== 1'b1 || out_m !== 1'b0 || vld_l !== 1'b1)
         $display("FAIL lsb_first_bit: got lsb=%b msb=%b vld=%b want 1 0 1", out_l, out_m, vld_l);
      else n_pass++;
      step(1'b1, 4'b0111);
      n_checks++;
      if (act !== exp_vec() || rdy_l !== 1'b0)
         $display("FAIL mid_hold: got %b want %b", act, exp_vec());
      else n_pass++;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (act !== 6'b100000) $display("FAIL mid_reset: got %b want %b", act, 6'b100000);
      else n_pass++;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step(1'b0, 4'h0);
         n_checks++;
         if (act !== 6'b100000)
            $display("FAIL post_reset_idle cyc%0d: got %b want %b", c, act, 6'b100000);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         step(($urandom_range(0, 2) != 0), 4'($urandom));
         n_checks++;
         if (act !== exp_vec() || !framing_agree)
            $display("FAIL random cyc%0d: got %b want %b", c, act, exp_vec());
         else n_pass++;
      end
      for (int c = 0; c < 10; c++) step(1'b0, 4'h0);
      n_checks++;
      if (act !== 6'b100000) $display("FAIL random_drain: got %b want %b", act, 6'b100000);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_bypass();
      test_reset_midstream();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
